ks_result_collector: RTL and testbench
======================================

KS_RESULT_COLLECTOR -- requirements
Module: ks_result_collector

Interface
REQ-001 Parameter WIDTH, default 64: adder operand and sum width.
REQ-002 Parameter LATENCY, default 7: cycles from operand issue to sum/cout on the adder outputs; legal range 1..32.
REQ-003 Parameter DEPTH, default 16: result FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 issue_valid  input  1  upstream presents an operand pair to the adder this cycle.
REQ-007 issue_ready  output  1  collector has a guaranteed slot for that result.
REQ-008 sum  input  WIDTH  adder sum output.
REQ-009 cout  input  1  adder carry-out.
REQ-010 res_valid  output  1  FIFO head holds a result.
REQ-011 res_ready  input  1  consumer accepts the head.
REQ-012 res_sum  output  WIDTH  head sum.
REQ-013 res_cout  output  1  head carry-out.
REQ-014 occupancy  output  clog2(DEPTH+1)  current FIFO entry count.

Function
REQ-015 Issue fires in cycle t when issue_valid and issue_ready are both 1; issue_valid while issue_ready=0 is ignored and not tracked.
REQ-016 Fire is tracked in a LATENCY-stage valid shift register; the sum/cout present in cycle t+LATENCY are written to the FIFO at the end of that cycle.
REQ-017 Cycles whose shift-register tap is 0 do not write, whatever sum/cout carry.
REQ-018 issue_ready = (occupancy + in-flight count) < DEPTH, from registered state only; no combinational path from res_ready or issue_valid.
REQ-019 In-flight count = number of set bits in the valid shift register.
REQ-020 The credit rule guarantees no FIFO write when full.
REQ-021 No write-through: a result written in cycle n first appears on res_valid/res_sum in cycle n+1.
REQ-022 res_valid = (occupancy != 0); a pop occurs when res_valid and res_ready are both 1.
REQ-023 Simultaneous write and pop leaves occupancy unchanged.
REQ-024 res_sum/res_cout stay stable while res_valid=1 and res_ready=0.
REQ-025 Read and write pointers wrap modulo DEPTH.
REQ-026 Results leave in issue order.
REQ-027 Sustained one result per cycle is achieved when DEPTH >= LATENCY+2 and res_ready is held at 1.
REQ-028 With smaller DEPTH, issue_ready throttles throughput and results are never lost.

Reset
REQ-029 Asserting rst_n low clears, asynchronously:
- valid shift register and FIFO pointers
- occupancy, res_valid, res_sum, res_cout
REQ-030 issue_ready is 1 in the first cycle after rst_n deasserts.
REQ-031 Reset mid-operation discards all in-flight and stored results.
REQ-032 Adder outputs arriving after reset release for operations issued before reset are never captured.

Configuration
REQ-033 Macro KS_COLLECT_STATS_EN defined: adds outputs stat_results (32 bits) and stat_carries (32 bits).
- stat_results increments on every pop.
- stat_carries increments on every pop with res_cout=1.
- Both wrap at 2^32 and reset to 0.
REQ-034 Macro KS_COLLECT_STATS_EN undefined: both ports and their counters are absent; all other behaviour is identical.

Verification (WIDTH=64, LATENCY=7, DEPTH=16)
REQ-035 Single issue in cycle 3; adder drives sum=0xC8, cout=0 in cycle 10 -> res_valid=1 and res_sum=0xC8 in cycle 11; occupancy returns to 0 after the pop.
REQ-036 issue_valid=1 and res_ready=1 for 100 cycles, incrementing operands -> issue_ready never drops; 100 results in order; no res_valid gaps after the first result.
REQ-037 res_ready=0, issue_valid=1 continuously -> exactly 16 fires, then issue_ready=0 and occupancy=16; raise res_ready -> 16 results drain in issue order and issue_ready returns to 1.
REQ-038 Adder result sum=0, cout=1 (a=all ones, b=0, cin=1) -> res_sum=0, res_cout=1.
REQ-039 rst_n pulsed low with 5 results in flight and 3 stored -> res_valid=0 and occupancy=0 immediately; issue_ready=1 after release; no result appears in the following 10 cycles.
REQ-040 With KS_COLLECT_STATS_EN defined, 10 pops of which 3 have cout=1 -> stat_results=10, stat_carries=3.

Source files
------------

// File: rtl/ks_result_collector.sv
// ----------------------------------------------------------------------------
// ks_result_collector
//
// Collects results from a fixed-latency pipelined adder into a result FIFO.
// Each accepted issue is tracked by a LATENCY-stage valid shift register; when
// its bit reaches the last stage, the adder's sum/cout in that cycle are
// written into the FIFO. Credits (FIFO occupancy plus in-flight issues) gate
// issue_ready, so the FIFO can never overflow and no result is ever dropped.
//
// Parameters:
//   WIDTH    adder operand/sum width
//   LATENCY  cycles from issue to sum/cout on the adder outputs (1..32)
//   DEPTH    result FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   issue_valid  upstream presents an operand pair to the adder
//   issue_ready  a FIFO slot is guaranteed for a result issued now
//   sum, cout    adder outputs
//   res_valid    FIFO head holds a result
//   res_ready    consumer accepts the head
//   res_sum      head sum
//   res_cout     head carry-out
//   occupancy    current FIFO entry count
//
// Optional feature (macro KS_COLLECT_STATS_EN):
//   stat_results  32-bit count of pops (wraps)
//   stat_carries  32-bit count of pops whose res_cout was 1 (wraps)
// ----------------------------------------------------------------------------
module ks_result_collector #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 7,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [WIDTH-1:0]           sum,
    input  logic                       cout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_sum,
    output logic                       res_cout,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef KS_COLLECT_STATS_EN
    ,
    output logic [31:0]                stat_results,
    output logic [31:0]                stat_carries
`endif
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] valid_sr;
    logic               fire;
    logic               push;
    logic               pop;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      credit_used;
    logic [WIDTH:0]     mem [DEPTH];
    logic [WIDTH:0]     head;

    assign fire      = issue_valid & issue_ready;
    assign push      = valid_sr[LATENCY-1];
    assign res_valid = (occupancy != '0);
    assign pop       = res_valid & res_ready;

    // Credits in use = stored results + results still inside the adder.
    // Built only from registers, so issue_ready has no combinational path
    // from issue_valid or res_ready.
    always_comb begin
        credit_used = CW'(occupancy);
        for (int i = 0; i < LATENCY; i++) begin
            credit_used = credit_used + CW'(valid_sr[i]);
        end
        issue_ready = (credit_used < CW'(DEPTH));
    end

    // Issue-tracking shift register: bit k set means an operation issued
    // k+1 cycles ago; the top bit marks the cycle its result is on sum/cout.
    // Reset clears it so results of pre-reset issues are never captured.
    generate
        if (LATENCY == 1) begin : g_sr_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_sr <= '0;
                end else begin
                    valid_sr <= fire;
                end
            end
        end else begin : g_sr_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_sr <= '0;
                end else begin
                    valid_sr <= {valid_sr[LATENCY-2:0], fire};
                end
            end
        end
    endgenerate

    // Result storage; contents need no reset because the head is masked
    // whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cout, sum};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + OW'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - OW'(1);
            end
        end
    end

    // Head is forced to zero when empty, which also makes it read zero
    // during and straight after reset.
    assign head     = res_valid ? mem[rd_ptr] : '0;
    assign res_sum  = head[WIDTH-1:0];
    assign res_cout = head[WIDTH];

`ifdef KS_COLLECT_STATS_EN
    // Pop statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_results <= '0;
            stat_carries <= '0;
        end else if (pop) begin
            stat_results <= stat_results + 32'd1;
            if (res_cout) begin
                stat_carries <= stat_carries + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ks_result_collector.sv
// ----------------------------------------------------------------------------
// tb_ks_result_collector
//
// Bench for ks_result_collector (WIDTH=64, LATENCY=7, DEPTH=16). A behavioural
// pipelined adder feeds the collector; every issue the bench expects to be
// accepted pushes {sum, cout, due cycle} onto a scoreboard queue, and the
// queue predicts occupancy, res_valid, issue_ready and the head result each
// cycle. Stats outputs are connected and checked when KS_COLLECT_STATS_EN is
// defined.
// ----------------------------------------------------------------------------
module tb_ks_result_collector;

    localparam int WIDTH   = 64;
    localparam int LATENCY = 7;
    localparam int DEPTH   = 16;
    localparam int OW      = $clog2(DEPTH + 1);

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic [OW-1:0]    occupancy;
`ifdef KS_COLLECT_STATS_EN
    logic [31:0]      stat_results;
    logic [31:0]      stat_carries;
`endif

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH:0]   pipe [LATENCY];

    exp_t sb[$];
    int   cyc;
    int   errors;
    int   checks;

    always #5 clk = ~clk;

    ks_result_collector #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .sum         (sum),
        .cout        (cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .occupancy   (occupancy)
`ifdef KS_COLLECT_STATS_EN
        ,
        .stat_results(stat_results),
        .stat_carries(stat_carries)
`endif
    );

    // Behavioural adder: computes every cycle, result appears LATENCY cycles
    // later regardless of whether the collector accepted the issue.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign {cout, sum} = pipe[LATENCY-1];

    task automatic compare(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Compares the DUT against the scoreboard for the current cycle and
    // retires the head if the consumer takes it at the coming edge.
    task automatic checkOutput(output logic exp_ready);
        int vis;
        vis = 0;
        foreach (sb[i]) begin
            if (sb[i].due < cyc) vis++;
        end
        exp_ready = (sb.size() < DEPTH);
        compare("occupancy",   (WIDTH+1)'(occupancy), (WIDTH+1)'(vis));
        compare("res_valid",   (WIDTH+1)'(res_valid), (WIDTH+1)'(vis != 0));
        compare("issue_ready", (WIDTH+1)'(issue_ready), (WIDTH+1)'(exp_ready));
        if (vis != 0) begin
            compare("res_sum",  {1'b0, res_sum}, {1'b0, sb[0].s});
            compare("res_cout", (WIDTH+1)'(res_cout), (WIDTH+1)'(sb[0].c));
            if (res_ready) void'(sb.pop_front());
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, record the
    // expected result of an accepted issue, then advance to the next fall.
    task automatic applyStimulus(input logic iv, input logic rr, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic cin);
        logic     rdy;
        logic [WIDTH:0] full;
        exp_t     e;
        issue_valid = iv;
        res_ready   = rr;
        op_a        = a;
        op_b        = b;
        op_cin      = cin;
        checkOutput(rdy);
        if (iv && rdy) begin
            full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            e.s   = full[WIDTH-1:0];
            e.c   = full[WIDTH];
            e.due = cyc + LATENCY;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < LATENCY + DEPTH + 4; i++) begin
            applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        res_ready   = 1'b0;
        op_a        = '0;
        op_b        = '0;
        op_cin      = 1'b0;

        // Power-on reset, released on a falling edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare("reset_occupancy", (WIDTH+1)'(occupancy), '0);
        compare("reset_res_valid", (WIDTH+1)'(res_valid), '0);
        compare("reset_res_sum",   {1'b0, res_sum}, '0);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Single issue: 100+100 = 0xC8 appears LATENCY+1 cycles later.
        applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 64'd100, 64'd100, 1'b0);
        drain();

        // All-ones + 0 + carry-in: sum 0, carry-out 1.
        applyStimulus(1'b1, 1'b1, {WIDTH{1'b1}}, '0, 1'b1);
        drain();

        // Sustained streaming with consumer always ready.
        $display("[TB] streaming 100 issues");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b1, 64'(i), 64'(i * 3), 1'(i));
        end
        drain();

        // Consumer stalled: credits run out at DEPTH, then drain in order.
        $display("[TB] fill with consumer stalled");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0, 64'(1000 + i), 64'd7, 1'b0);
        end
        compare("full_occupancy",   (WIDTH+1)'(occupancy), (WIDTH+1)'(DEPTH));
        compare("full_issue_ready", (WIDTH+1)'(issue_ready), '0);
        drain();

        // Reset with 3 stored and 5 in flight.
        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'(50 + i), 64'd1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 64'(70 + i), 64'd2, 1'b1);
        compare("pre_reset_occupancy", (WIDTH+1)'(occupancy), (WIDTH+1)'(3));
        issue_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        compare("async_res_valid", (WIDTH+1)'(res_valid), '0);
        compare("async_occupancy", (WIDTH+1)'(occupancy), '0);
        sb.delete();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, '0, '0, 1'b0);

        // Ten results, three with carry-out, for the statistics counters.
        for (int i = 0; i < 10; i++) begin
            if (i < 3) applyStimulus(1'b1, 1'b1, {WIDTH{1'b1}}, 64'd1, 1'b0);
            else       applyStimulus(1'b1, 1'b1, 64'(i), 64'(i), 1'b0);
        end
        drain();
`ifdef KS_COLLECT_STATS_EN
        compare("stat_results", (WIDTH+1)'(stat_results), (WIDTH+1)'(10));
        compare("stat_carries", (WIDTH+1)'(stat_carries), (WIDTH+1)'(3));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
